// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared encodings and widths for the 32-bit-over-16-bit SRAM sequencer
package sram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int SRAM_AW      = 18;
   localparam int SRAM_DW      = 16;
   localparam int WORD_IDX_MSB = 18;
   localparam int WORD_IDX_LSB = 2;
   localparam int WORD_IDX_W   = WORD_IDX_MSB - WORD_IDX_LSB + 1;

endpackage

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - sequences one 32-bit MEM-stage access as two 16-bit SRAM half-word phases
// The FSM, phase counter and DQ tri-state driver all live here.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int ACC_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic                 rd_en,
   input  logic [31:0]          address,
   input  logic [31:0]          write_data,
   output logic [31:0]          read_data,
   output logic                 pause,
   inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
   output logic [SRAM_AW-1:0]   SRAM_ADDR,
   output logic                 SRAM_UB_N,
   output logic                 SRAM_LB_N,
   output logic                 SRAM_WE_N,
   output logic                 SRAM_CE_N,
   output logic                 SRAM_OE_N
);

   localparam logic [3:0] LAST_CNT = 4'(ACC_CYCLES - 1);

   state_t                  state;
   logic [3:0]              cnt;
   logic                    op_wr;
   logic [WORD_IDX_W-1:0]   word_idx;
   logic [31:0]             wdata;
   logic [SRAM_DW-1:0]      lo_half;

   logic                    phase_end;
   logic                    in_phase;
   logic                    is_hi;
   logic                    unused_addr_bits;

   assign phase_end = (cnt == LAST_CNT);
   assign in_phase  = (state == LO) || (state == HI);
   assign is_hi     = (state == HI);

   // Address bits outside the word index are deliberately discarded (wraps at 512 KiB).
   assign unused_addr_bits = ^{address[31:WORD_IDX_MSB+1], address[WORD_IDX_LSB-1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         op_wr     <= 1'b0;
         word_idx  <= '0;
         wdata     <= '0;
         lo_half   <= '0;
         read_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (wr_en || rd_en) begin
                  op_wr    <= wr_en;
                  word_idx <= address[WORD_IDX_MSB:WORD_IDX_LSB];
                  wdata    <= write_data;
                  state    <= LO;
               end
            end
            LO: begin
               if (phase_end) begin
                  if (!op_wr)
                     lo_half <= SRAM_DQ;
                  cnt   <= '0;
                  state <= HI;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            HI: begin
               if (phase_end) begin
                  if (!op_wr)
                     read_data <= {SRAM_DQ, lo_half};
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Pin decode uses only registered state, so an async reset releases the bus immediately.
   assign pause     = (state == IDLE && (rd_en || wr_en)) || in_phase;
   assign SRAM_ADDR = in_phase ? {word_idx, is_hi} : '0;
   assign SRAM_WE_N = !(in_phase && op_wr && !phase_end);
   assign SRAM_OE_N = !(in_phase && !op_wr);
   assign SRAM_DQ   = (in_phase && op_wr) ? (is_hi ? wdata[31:16] : wdata[15:0]) : 'z;

   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed bench for sram_ctrl at ACC_CYCLES 2 and 4 with half-word SRAM models
module tb_sram_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
   logic [31:0] adr_a = 0, wd_a = 0, adr_b = 0, wd_b = 0;
   logic [31:0] rdata_a, rdata_b;
   logic        pause_a, pause_b;
   wire  [15:0] dq_a, dq_b;
   logic [17:0] sa_a, sa_b;
   logic        ub_a, lb_a, we_a, ce_a, oe_a;
   logic        ub_b, lb_b, we_b, ce_b, oe_b;

   logic [15:0] mem_a [0:255];
   logic [15:0] mem_b [0:255];

   int n_cmp = 0;
   int n_bad = 0;
   logic sel = 1'b0;

   sram_ctrl #(.ACC_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst), .wr_en(wr_a), .rd_en(rd_a), .address(adr_a), .write_data(wd_a),
      .read_data(rdata_a), .pause(pause_a), .SRAM_DQ(dq_a), .SRAM_ADDR(sa_a),
      .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a), .SRAM_WE_N(we_a), .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a));

   sram_ctrl #(.ACC_CYCLES(4)) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_b), .rd_en(rd_b), .address(adr_b), .write_data(wd_b),
      .read_data(rdata_b), .pause(pause_b), .SRAM_DQ(dq_b), .SRAM_ADDR(sa_b),
      .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b), .SRAM_WE_N(we_b), .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b));

   pullup (dq_a);
   pullup (dq_b);
   assign dq_a = (!oe_a) ? mem_a[sa_a[7:0]] : 16'bz;
   assign dq_b = (!oe_b) ? mem_b[sa_b[7:0]] : 16'bz;

   always @(posedge clk) if (!we_a) mem_a[sa_a[7:0]] <= dq_a;
   always @(posedge clk) if (!we_b) mem_b[sa_b[7:0]] <= dq_b;

   logic        cur_pause, cur_we, cur_oe;
   logic [17:0] cur_addr;
   logic [31:0] cur_rdata;
   assign cur_pause = sel ? pause_b : pause_a;
   assign cur_we    = sel ? we_b    : we_a;
   assign cur_oe    = sel ? oe_b    : oe_a;
   assign cur_addr  = sel ? sa_b    : sa_a;
   assign cur_rdata = sel ? rdata_b : rdata_a;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic wr, input logic rd,
                        input logic [31:0] a, input logic [31:0] d);
      if (s) begin
         wr_b = wr; rd_b = rd; adr_b = a; wd_b = d;
      end else begin
         wr_a = wr; rd_a = rd; adr_a = a; wd_a = d;
      end
   endtask

   task automatic run_access(input string tag, input logic s, input logic wr, input logic rd,
                             input logic [31:0] a, input logic [31:0] d, input int acc,
                             input int exp_high, input logic [15:0] exp_we, input logic [15:0] exp_oe,
                             input logic [17:0] exp_alo, input logic [17:0] exp_ahi,
                             input logic [31:0] exp_rd);
      int          n;
      logic [15:0] wev, oev;
      logic [17:0] alo, ahi;
      n = 0; wev = '0; oev = '0; alo = '0; ahi = '0;
      sel = s;
      tick();
      drive(s, wr, rd, a, d);
      #1;
      while (cur_pause === 1'b1 && n < 40) begin
         wev = {wev[14:0], cur_we};
         oev = {oev[14:0], cur_oe};
         if (n == 1)       alo = cur_addr;
         if (n == 1 + acc) ahi = cur_addr;
         n++;
         tick();
         drive(s, 1'b0, 1'b0, a, d);
         #1;
      end
      check({tag, " pause_high"}, 32'(n), 32'(exp_high));
      check({tag, " we_n_seq"}, {16'h0, wev}, {16'h0, exp_we});
      check({tag, " oe_n_seq"}, {16'h0, oev}, {16'h0, exp_oe});
      check({tag, " addr_lo"}, {14'h0, alo}, {14'h0, exp_alo});
      check({tag, " addr_hi"}, {14'h0, ahi}, {14'h0, exp_ahi});
      check({tag, " read_data_done"}, cur_rdata, exp_rd);
   endtask

   initial begin
      logic [11:0] pv;
      int          lo_cnt;

      // Reset state of both instances
      repeat (2) @(posedge clk);
      #1;
      check("rst pause_a", {31'h0, pause_a}, 32'h0);
      check("rst we_n_a", {31'h0, we_a}, 32'h1);
      check("rst oe_n_a", {31'h0, oe_a}, 32'h1);
      check("rst addr_a", {14'h0, sa_a}, 32'h0);
      check("rst rdata_a", rdata_a, 32'h0);
      check("rst dq_a released", {16'h0, dq_a}, 32'h0000_ffff);
      check("rst ce_ub_lb_a", {29'h0, ce_a, ub_a, lb_a}, 32'h0);
      check("rst we_oe_b", {30'h0, we_b, oe_b}, 32'h3);
      check("rst rdata_b", rdata_b, 32'h0);
      rst = 1'b0;

      // Write then read back, ACC_CYCLES=2
      run_access("wr10", 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2,
                 5, 16'h0015, 16'h001f, 18'd8, 18'd9, 32'h0);
      check("wr10 mem8", {16'h0, mem_a[8]}, 32'h0000_beef);
      check("wr10 mem9", {16'h0, mem_a[9]}, 32'h0000_dead);
      run_access("rd10", 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 2,
                 5, 16'h001f, 16'h0010, 18'd8, 18'd9, 32'hDEADBEEF);

      // Both requests high: write wins, read_data untouched
      run_access("both20", 1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678, 2,
                 5, 16'h0015, 16'h001f, 18'd16, 18'd17, 32'hDEADBEEF);
      check("both20 mem16", {16'h0, mem_a[16]}, 32'h0000_5678);
      check("both20 mem17", {16'h0, mem_a[17]}, 32'h0000_1234);

      // Request held for two back-to-back reads
      sel = 1'b0;
      tick();
      drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h0);
      #1;
      pv = '0; lo_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         pv = {pv[10:0], pause_a};
         if (sa_a == 18'd16 && !oe_a) lo_cnt++;
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      check("b2b pause_seq", {20'h0, pv}, 32'h0000_0fbe);
      check("b2b lo_cycles", 32'(lo_cnt), 32'd4);
      check("b2b read_data", rdata_a, 32'h12345678);

      // Reset during the HI phase of a write
      tick();
      drive(1'b0, 1'b1, 1'b0, 32'h40, 32'hAAAA5555);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'h40, 32'hAAAA5555);
      tick();
      tick();
      check("midrst pre we_n", {31'h0, we_a}, 32'h0);
      check("midrst pre addr", {14'h0, sa_a}, 32'd33);
      rst = 1'b1;
      #1;
      check("midrst we_n", {31'h0, we_a}, 32'h1);
      check("midrst dq released", {16'h0, dq_a}, 32'h0000_ffff);
      check("midrst pause", {31'h0, pause_a}, 32'h0);
      check("midrst addr", {14'h0, sa_a}, 32'h0);
      check("midrst read_data", rdata_a, 32'h0);
      #2;
      rst = 1'b0;
      run_access("postrst rd10", 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 2,
                 5, 16'h001f, 16'h0010, 18'd8, 18'd9, 32'hDEADBEEF);

      // Aliasing with ACC_CYCLES=4
      run_access("alias wr", 1'b1, 1'b1, 1'b0, 32'h0008_0004, 32'hCAFEF00D, 4,
                 9, 16'h0111, 16'h01ff, 18'd2, 18'd3, 32'h0);
      check("alias mem2", {16'h0, mem_b[2]}, 32'h0000_f00d);
      check("alias mem3", {16'h0, mem_b[3]}, 32'h0000_cafe);
      run_access("alias rd", 1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 4,
                 9, 16'h01ff, 16'h0100, 18'd2, 18'd3, 32'hCAFEF00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
